// File: rtl/jk_bank_arbiter.sv
// Bank of NBITS JK state bits shared by NREQ requesters through a round-robin
// arbiter and a three-state IDLE/APPLY/DONE command sequencer.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    jk_in,
  input  logic [AW*NREQ-1:0]   addr_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy,
  output logic [NBITS-1:0]     q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] NBITS_W = (AW+1)'(NBITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     win_q;
  logic [1:0]        cmd_jk_q;
  logic [AW-1:0]     cmd_addr_q;
  logic [NBITS-1:0]  q_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   ack_q;
  logic              err_q;

  logic [PW-1:0]     win_d;
  logic [1:0]        win_jk_d;
  logic [AW-1:0]     win_addr_d;
  logic [NBITS-1:0]  q_d;
  logic              any_req;
  logic              addr_ok;

  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == PW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Scan from the farthest offset back to ptr so the nearest set request wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    win_d      = '0;
    win_jk_d   = '0;
    win_addr_d = '0;
    any_req    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rot_idx(ptr_q, k)]) begin
        win_d   = rot_idx(ptr_q, k);
        any_req = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_d == PW'(i)) begin
        win_jk_d   = jk_in[2*i +: 2];
        win_addr_d = addr_in[AW*i +: AW];
      end
    end
  end

  // Out-of-range addresses match no bit position, so the bank holds for them.
  always_comb begin
    q_d     = q_q;
    addr_ok = ({1'b0, cmd_addr_q} < NBITS_W);
    for (int b = 0; b < NBITS; b++) begin
      if (cmd_addr_q == AW'(b)) begin
        case (cmd_jk_q)
          2'b01:   q_d[b] = 1'b0;
          2'b10:   q_d[b] = 1'b1;
          2'b11:   q_d[b] = ~q_q[b];
          default: q_d[b] = q_q[b];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cmd_jk_q   <= '0;
      cmd_addr_q <= '0;
      // NOTE: the bank is cleared by reset because its contents are visible flag state.
      q_q        <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q      <= win_d;
            cmd_jk_q   <= win_jk_d;
            cmd_addr_q <= win_addr_d;
            gnt_q      <= onehot(win_d);
            state_q    <= APPLY;
          end
        end
        APPLY: begin
          gnt_q   <= '0;
          ack_q   <= onehot(win_q);
          q_q     <= q_d;
          err_q   <= ~addr_ok;
          ptr_q   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
          state_q <= DONE;
        end
        DONE: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);
  assign q    = q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed scenarios plus random
// commands checked against a behavioural arbitration/JK model.
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int AW    = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  jk_in;
  logic [11:0] addr_in;
  logic [3:0]  gnt, ack;
  logic        err, busy;
  logic [7:0]  q;

  logic [3:0]  req6;
  logic [7:0]  jk6;
  logic [11:0] addr6;
  logic [3:0]  gnt6, ack6;
  logic        err6, busy6;
  logic [5:0]  q6;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_ptr    = 0;
  logic [7:0]  m_q      = '0;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW)) u_dut (
    .clk(clk), .rst(rst), .req(req), .jk_in(jk_in), .addr_in(addr_in),
    .gnt(gnt), .ack(ack), .err(err), .busy(busy), .q(q)
  );

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(6), .AW(AW)) u_dut6 (
    .clk(clk), .rst(rst), .req(req6), .jk_in(jk6), .addr_in(addr6),
    .gnt(gnt6), .ack(ack6), .err(err6), .busy(busy6), .q(q6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int model_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Characteristic equation Q+ = J&~Q | ~K&Q.
  function automatic logic [7:0] model_jk(input logic [7:0] cur, input logic [1:0] jk, input int a);
    logic [7:0] nxt;
    nxt = cur;
    if (a < NBITS) nxt[a] = (jk[1] & ~cur[a]) | (~jk[0] & cur[a]);
    return nxt;
  endfunction

  function automatic logic [3:0] oh(input int w);
    logic [3:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0; req6 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_q   = '0;
  endtask

  // Runs one full arbitration on the main instance from an IDLE negedge; r must be nonzero.
  task automatic issue(input logic [3:0] r, input logic [7:0] jk, input logic [11:0] ad, input string tag);
    int w;
    int ca;
    logic [1:0] cj;
    logic [3:0] eg;
    req = r; jk_in = jk; addr_in = ad;
    w  = model_winner(r, m_ptr);
    cj = jk[2*w +: 2];
    ca = int'(ad[3*w +: 3]);
    eg = oh(w);
    @(negedge clk);
    n_checks++;
    if (gnt !== eg || busy !== 1'b1 || ack !== 4'b0) begin
      n_fail++;
      $display("FAIL %s grant: gnt=%b busy=%b ack=%b, expected gnt=%b busy=1 ack=0000", tag, gnt, busy, ack, eg);
    end
    req = 4'($urandom); jk_in = 8'($urandom); addr_in = 12'($urandom);
    m_q   = model_jk(m_q, cj, ca);
    m_ptr = (w + 1) % NREQ;
    @(negedge clk);
    n_checks++;
    if (ack !== eg || gnt !== 4'b0 || err !== 1'b0 || q !== m_q) begin
      n_fail++;
      $display("FAIL %s apply: ack=%b gnt=%b err=%b q=%h, expected ack=%b gnt=0000 err=0 q=%h", tag, ack, gnt, err, q, eg, m_q);
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0 || err !== 1'b0 || busy !== 1'b0 || q !== m_q) begin
      n_fail++;
      $display("FAIL %s done: ack=%b err=%b busy=%b q=%h, expected ack=0000 err=0 busy=0 q=%h", tag, ack, err, busy, q, m_q);
    end
    req = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; jk_in = '0; addr_in = '0;
    req6 = '0; jk6 = '0; addr6 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_q = '0;
    @(negedge clk);
    n_checks++;
    if (q !== 8'h00 || gnt !== 4'b0 || ack !== 4'b0 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: q=%h gnt=%b ack=%b err=%b busy=%b, expected all zero", q, gnt, ack, err, busy);
    end
  endtask

  task automatic test_single();
    logic [1:0] seq   [5] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    logic [7:0] exp_q [5] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      issue(4'b0001, {6'b0, seq[i]}, 12'd3, "single");
      n_checks++;
      if (q !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_q[%0d]: q=%h expected %h", i, q, exp_q[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp_q [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F};
    do_reset();
    req = 4'b1111; jk_in = 8'b1010_1010; addr_in = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== oh(i % 4)) begin
        n_fail++;
        $display("FAIL contention_gnt[%0d]: gnt=%b expected %b", i, gnt, oh(i % 4));
      end
      @(negedge clk);
      n_checks++;
      if (ack !== oh(i % 4) || q !== exp_q[i]) begin
        n_fail++;
        $display("FAIL contention_apply[%0d]: ack=%b q=%h expected ack=%b q=%h", i, ack, q, oh(i % 4), exp_q[i]);
      end
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0 || ack !== 4'b0) begin
        n_fail++;
        $display("FAIL contention_gap[%0d]: gnt=%b ack=%b expected both 0000", i, gnt, ack);
      end
    end
    req = '0;
    m_q = 8'h0F; m_ptr = 1;
  endtask

  task automatic test_fairness();
    int order [4] = '{1, 2, 1, 2};
    do_reset();
    req = 4'b0010; jk_in = '0; addr_in = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== oh(order[i])) begin
        n_fail++;
        $display("FAIL fairness_gnt[%0d]: gnt=%b expected %b", i, gnt, oh(order[i]));
      end
      if (i == 0) req = 4'b0110;
      @(negedge clk);
      @(negedge clk);
    end
    req = '0;
    m_ptr = 3;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if (i % 7 == 6) begin
        req = '0; jk_in = 8'($urandom); addr_in = 12'($urandom);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || q !== m_q) begin
          n_fail++;
          $display("FAIL random_idle[%0d]: gnt=%b busy=%b q=%h expected 0000 0 %h", i, gnt, busy, q, m_q);
        end
      end
      issue(4'($urandom_range(1, 15)), 8'($urandom), 12'($urandom), "random");
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] addrs [3] = '{3'd7, 3'd5, 3'd6};
    logic       exp_e [3] = '{1'b1, 1'b0, 1'b1};
    logic [5:0] exp_q [3] = '{6'h00, 6'h20, 6'h20};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req6 = 4'b0001; jk6 = 8'b0000_0010; addr6 = {9'd0, addrs[i]};
      @(negedge clk);
      n_checks++;
      if (gnt6 !== 4'b0001) begin
        n_fail++;
        $display("FAIL oor_gnt[%0d]: gnt=%b expected 0001", i, gnt6);
      end
      req6 = '0;
      @(negedge clk);
      n_checks++;
      if (ack6 !== 4'b0001 || err6 !== exp_e[i] || q6 !== exp_q[i]) begin
        n_fail++;
        $display("FAIL oor_apply[%0d]: ack=%b err=%b q=%h expected 0001 %b %h", i, ack6, err6, q6, exp_e[i], exp_q[i]);
      end
      @(negedge clk);
      n_checks++;
      if (ack6 !== 4'b0 || err6 !== 1'b0) begin
        n_fail++;
        $display("FAIL oor_done[%0d]: ack=%b err=%b expected 0000 0", i, ack6, err6);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    issue(4'b0100, 8'b0010_0000, 12'd5 << 6, "mid_setup");
    n_checks++;
    if (q !== 8'h20) begin
      n_fail++;
      $display("FAIL mid_setup_q: q=%h expected 20", q);
    end
    req = 4'b0100; jk_in = 8'b0011_0000; addr_in = 12'd5 << 6;
    @(negedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    #1;
    n_checks++;
    if (q !== 8'h00 || busy !== 1'b0 || gnt !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: q=%h busy=%b gnt=%b expected 00 0 0000", q, busy, gnt);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (ack !== 4'b0 || q !== 8'h00) begin
        n_fail++;
        $display("FAIL mid_reset_hold[%0d]: ack=%b q=%h expected 0000 00", i, ack, q);
      end
    end
    rst = 1'b0;
    m_ptr = 0; m_q = '0;
    issue(4'b1111, 8'($urandom), 12'($urandom), "post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_random();
    test_out_of_range();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
